// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Definitions shared by the systolic feeder, its delay lines, the PE array
// and the bench.
//   DATA_W           operand width carried on every edge lane
//   ACC_W            PE accumulator width
//   feeder_state_t   feeder FSM states
//   tileDoneLatency  cycles from the cycle holding an accepted start to the
//                    cycle holding tile_done
// ----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } feeder_state_t;

    // Each state lasts a whole number of cycles:
    // CLEAR(1) + FEED(k) + FLUSH(rows+cols) + DRAIN(drain) + DONE(1).
    // An empty tile skips straight from CLEAR to DONE.
    // k must already be clamped to the buffer depth.
    function automatic int tileDoneLatency(input int k, input int rows,
                                           input int cols, input int drain);
        return (k == 0) ? 2 : (2 + k + rows + cols + drain);
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// ----------------------------------------------------------------------------
// systolic_feeder_if
// Bundles the tile request/status handshake, the A/B operand buffer read
// ports and the west/north array edges of the systolic feeder.
//   master : the feeder side (issues buffer reads, drives the array edges)
//   slave  : the environment (requests tiles, returns buffer data)
// ----------------------------------------------------------------------------
interface systolic_feeder_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int AW   = 8
);
    logic                 start;
    logic [AW:0]          k_len;
    logic                 a_rd_en;
    logic [AW-1:0]        a_rd_addr;
    logic [ROWS*8-1:0]    a_rd_data;
    logic                 b_rd_en;
    logic [AW-1:0]        b_rd_addr;
    logic [COLS*8-1:0]    b_rd_data;
    logic [ROWS*8-1:0]    west_out;
    logic [COLS*8-1:0]    north_out;
    logic                 pe_clear;
    logic                 busy;
    logic                 tile_done;

    modport master (
        input  start, k_len, a_rd_data, b_rd_data,
        output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               west_out, north_out, pe_clear, busy, tile_done
    );

    modport slave (
        output start, k_len, a_rd_data, b_rd_data,
        input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               west_out, north_out, pe_clear, busy, tile_done
    );
endinterface

// File: rtl/skew_line.sv
// ----------------------------------------------------------------------------
// skew_line
// DEPTH-stage delay line for one array edge lane. Slots whose valid bit is
// low inject zero, so the array only ever sees real operands or zeros.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_vld      : i_data holds a real operand this cycle
//   i_data     : operand byte from the buffer
//   o_data     : operand byte delayed by DEPTH cycles (last stage is the
//                lane's output register)
// ----------------------------------------------------------------------------
module skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_vld ? i_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// ----------------------------------------------------------------------------
// systolic_feeder
// Edge driver for the output-stationary PE array. On start it clears the
// array, reads K operand words from the A and B buffers, skews them onto the
// west and north edges, flushes zeros through the array, waits for the corner
// accumulator to settle and pulses tile_done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : systolic_feeder_if master (start/k_len request, busy,
//                tile_done, A/B buffer read ports, west/north edges,
//                pe_clear)
// ----------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int AW    = 8,
    parameter int DRAIN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_feeder_if.master  bus
);

    localparam int FLUSH_LEN = ROWS + COLS;
    localparam int K_MAX_I   = 1 << AW;
    localparam int MAX_CNT   = (K_MAX_I > FLUSH_LEN)
                             ? ((K_MAX_I > DRAIN) ? K_MAX_I : DRAIN)
                             : ((FLUSH_LEN > DRAIN) ? FLUSH_LEN : DRAIN);
    localparam int CNT_W     = $clog2(MAX_CNT + 1);

    localparam logic [AW:0]      K_MAX      = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]      K_ONE      = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN > 0) ? DRAIN - 1 : 0);

    feeder_state_t    r_state;
    feeder_state_t    w_nextState;
    logic [AW:0]      r_kLen;
    logic [AW:0]      w_kClamp;
    logic [AW:0]      w_kLastWide;
    logic [CNT_W-1:0] w_kLast;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_rdEn;
    logic             w_clear;
    logic             w_done;
    logic             r_aVld;
    logic             r_bVld;

    logic [ROWS*DATA_W-1:0] w_west;
    logic [COLS*DATA_W-1:0] w_north;

    // Requests deeper than the buffer are clamped to the buffer depth.
    assign w_kClamp    = (bus.k_len > K_MAX) ? K_MAX : bus.k_len;
    assign w_kLastWide = r_kLen - K_ONE;
    assign w_kLast     = CNT_W'(w_kLastWide);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kLen  <= '0;
            r_aVld  <= 1'b0;
            r_bVld  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (r_state == S_IDLE && bus.start) begin
                r_kLen <= w_kClamp;
            end
            // Buffer data lags its strobe by one cycle; so does its valid bit.
            r_aVld <= w_rdEn;
            r_bVld <= w_rdEn;
        end
    end

    // One shared counter times FEED, FLUSH and DRAIN; it is zero on entry
    // to each of them.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_rdEn      = 1'b0;
        w_clear     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nextCnt = '0;
                if (bus.start) begin
                    w_nextState = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_clear     = 1'b1;
                w_nextCnt   = '0;
                w_nextState = (r_kLen == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                w_rdEn = 1'b1;
                if (r_cnt == w_kLast) begin
                    w_nextCnt   = '0;
                    w_nextState = S_FLUSH;
                end else begin
                    w_nextCnt = r_cnt + CNT_ONE;
                end
            end
            S_FLUSH: begin
                if (r_cnt == FLUSH_LAST) begin
                    w_nextCnt   = '0;
                    w_nextState = (DRAIN > 0) ? S_DRAIN : S_DONE;
                end else begin
                    w_nextCnt = r_cnt + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_nextCnt   = '0;
                    w_nextState = S_DONE;
                end else begin
                    w_nextCnt = r_cnt + CNT_ONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_nextCnt   = '0;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextCnt   = '0;
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Lane r of each edge is r+1 deep, producing the diagonal wavefront.
    for (genvar r = 0; r < ROWS; r++) begin : g_west
        skew_line #(.DEPTH(r + 1)) u_west (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_vld  (r_aVld),
            .i_data (bus.a_rd_data[r*DATA_W +: DATA_W]),
            .o_data (w_west[r*DATA_W +: DATA_W])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_north
        skew_line #(.DEPTH(c + 1)) u_north (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_vld  (r_bVld),
            .i_data (bus.b_rd_data[c*DATA_W +: DATA_W]),
            .o_data (w_north[c*DATA_W +: DATA_W])
        );
    end

    assign bus.a_rd_en   = w_rdEn;
    assign bus.b_rd_en   = w_rdEn;
    assign bus.a_rd_addr = r_cnt[AW-1:0];
    assign bus.b_rd_addr = r_cnt[AW-1:0];
    assign bus.west_out  = w_west;
    assign bus.north_out = w_north;
    assign bus.pe_clear  = w_clear;
    assign bus.tile_done = w_done;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// ----------------------------------------------------------------------------
// tb_systolic_feeder
// Bench for systolic_feeder with a 2x2 array, 8-deep buffers and DRAIN=3.
// Each tile request pushes its expected per-cycle edge/strobe/status values
// and its expected dot products; a falling-edge monitor pops and compares
// them. A behavioural PE array driven by the edges supplies the accumulators.
// ----------------------------------------------------------------------------
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int R  = 2;
    localparam int C  = 2;
    localparam int AW = 3;
    localparam int D  = 3;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int              cyc;
        logic [R*8-1:0]  west;
        logic [C*8-1:0]  north;
        logic            rd;
        logic [AW-1:0]   addr;
        logic            clear;
        logic            done;
        logic            busy;
    } expCycle_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vecCount;
    int   errCount;
    int   lastS;
    int   lastLat;

    logic [R*8-1:0] memA [DEPTH];
    logic [C*8-1:0] memB [DEPTH];

    expCycle_t             expQ [$];
    logic [R*C*32-1:0]     resQ [$];
    expCycle_t             monE;
    logic [R*C*32-1:0]     monRes;

    logic [7:0]  peA [R][C];
    logic [7:0]  peB [R][C];
    logic [31:0] acc [R][C];
    logic [7:0]  aIn;
    logic [7:0]  bIn;

    systolic_feeder_if #(.ROWS(R), .COLS(C), .AW(AW)) bus ();

    systolic_feeder #(.ROWS(R), .COLS(C), .AW(AW), .DRAIN(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffers: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rd_data <= memA[bus.a_rd_addr];
        if (bus.b_rd_en) bus.b_rd_data <= memB[bus.b_rd_addr];
    end

    // Output-stationary PE array sampling the edges on the falling edge.
    always @(negedge clk) begin
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (bus.pe_clear) begin
                    peA[r][c] <= 8'd0;
                    peB[r][c] <= 8'd0;
                    acc[r][c] <= 32'd0;
                end else begin
                    if (c == 0) aIn = bus.west_out[r*8 +: 8];
                    else        aIn = peA[r][c-1];
                    if (r == 0) bIn = bus.north_out[c*8 +: 8];
                    else        bIn = peB[r-1][c];
                    peA[r][c] <= aIn;
                    peB[r][c] <= bIn;
                    acc[r][c] <= acc[r][c] + aIn * bIn;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] expv);
        vecCount++;
        if (obs !== expv) begin
            errCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cyc, obs, expv);
        end
    endtask

    // Scoreboard monitor: cycles with no pending entry must be fully idle.
    always @(negedge clk) begin
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            monE = expQ.pop_front();
        end else begin
            monE = '{cyc: cyc, west: '0, north: '0, rd: 1'b0, addr: '0,
                     clear: 1'b0, done: 1'b0, busy: 1'b0};
        end
        checkOutput("west_out",  bus.west_out,  monE.west);
        checkOutput("north_out", bus.north_out, monE.north);
        checkOutput("a_rd_en",   bus.a_rd_en,   monE.rd);
        checkOutput("b_rd_en",   bus.b_rd_en,   monE.rd);
        if (monE.rd) begin
            checkOutput("a_rd_addr", bus.a_rd_addr, monE.addr);
            checkOutput("b_rd_addr", bus.b_rd_addr, monE.addr);
        end
        checkOutput("pe_clear",  bus.pe_clear,  monE.clear);
        checkOutput("tile_done", bus.tile_done, monE.done);
        checkOutput("busy",      bus.busy,      monE.busy);
        if (monE.done) begin
            checkOutput("resQ_pending", resQ.size(), 1);
            if (resQ.size() > 0) begin
                monRes = resQ.pop_front();
                for (int r = 0; r < R; r++) begin
                    for (int c = 0; c < C; c++) begin
                        checkOutput($sformatf("acc[%0d][%0d]", r, c),
                                    acc[r][c], monRes[(r*C+c)*32 +: 32]);
                    end
                end
            end
        end
    end

    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fillRandom(input int n);
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < R; r++) memA[k][r*8 +: 8] = 8'($urandom_range(0, 255));
            for (int c = 0; c < C; c++) memB[k][c*8 +: 8] = 8'($urandom_range(0, 255));
        end
    endtask

    // Raises start for one cycle; when track is set, pushes the expected
    // per-cycle behaviour and the expected dot products of the tile.
    task automatic applyStimulus(input int kLen, input bit track);
        int             kEff;
        int             s;
        int             f;
        int             kk;
        int             sum;
        logic [AW:0]    kBits;
        expCycle_t      e;
        logic [R*C*32-1:0] res;
        kEff  = (kLen > DEPTH) ? DEPTH : kLen;
        kBits = kLen[AW:0];
        bus.k_len = kBits;
        bus.start = 1'b1;
        s = cyc;
        f = s + 2;
        if (track) begin
            $display("[TB] tile k_len=%0d at cycle %0d", kLen, s);
            lastS   = s;
            lastLat = tileDoneLatency(kEff, R, C, D);
            for (int t = s + 1; t <= s + lastLat; t++) begin
                e.cyc   = t;
                e.clear = (t == s + 1);
                e.done  = (t == s + lastLat);
                e.busy  = 1'b1;
                e.rd    = (t >= f) && (t < f + kEff);
                e.addr  = AW'(t - f);
                e.west  = '0;
                e.north = '0;
                for (int r = 0; r < R; r++) begin
                    kk = t - f - 2 - r;
                    if (kk >= 0 && kk < kEff) e.west[r*8 +: 8] = memA[kk][r*8 +: 8];
                end
                for (int c = 0; c < C; c++) begin
                    kk = t - f - 2 - c;
                    if (kk >= 0 && kk < kEff) e.north[c*8 +: 8] = memB[kk][c*8 +: 8];
                end
                expQ.push_back(e);
            end
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    sum = 0;
                    for (int k = 0; k < kEff; k++) begin
                        sum += int'(memA[k][r*8 +: 8]) * int'(memB[k][c*8 +: 8]);
                    end
                    res[(r*C+c)*32 +: 32] = sum;
                end
            end
            resQ.push_back(res);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        vecCount      = 0;
        errCount      = 0;
        cyc           = 0;
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.a_rd_data = '0;
        bus.b_rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            memA[k] = '0;
            memB[k] = '0;
        end
        #2 rst_n = 1'b0;
        stepTo(4);
        rst_n = 1'b1;
        stepTo(6);

        // Worked example: A rows [1,2,3],[4,5,6]; B columns [7,8,9],[1,1,1].
        memA[0] = {8'd4, 8'd1};  memB[0] = {8'd1, 8'd7};
        memA[1] = {8'd5, 8'd2};  memB[1] = {8'd1, 8'd8};
        memA[2] = {8'd6, 8'd3};  memB[2] = {8'd1, 8'd9};
        applyStimulus(3, 1'b1);
        stepTo(lastS + lastLat + 2);

        // Empty tile: clear then done, no reads, silent edges.
        applyStimulus(0, 1'b1);
        stepTo(lastS + lastLat + 2);

        // Single all-ones step: every product is 0xFE01.
        memA[0] = 16'hFFFF;
        memB[0] = 16'hFFFF;
        applyStimulus(1, 1'b1);
        stepTo(lastS + lastLat + 2);

        // Second start during FEED must be ignored.
        fillRandom(3);
        applyStimulus(3, 1'b1);
        stepTo(lastS + 3);
        applyStimulus(5, 1'b0);
        stepTo(lastS + lastLat + 2);

        // Reset in the middle of FLUSH, then a clean tile.
        fillRandom(5);
        applyStimulus(5, 1'b1);
        stepTo(lastS + 2 + 5 + 1);
        rst_n = 1'b0;
        expQ.delete();
        resQ.delete();
        stepTo(cyc + 2);
        rst_n = 1'b1;
        stepTo(cyc + 3);
        fillRandom(3);
        applyStimulus(3, 1'b1);
        stepTo(lastS + lastLat + 2);

        // Back-to-back tiles: second start in the cycle after tile_done.
        fillRandom(4);
        applyStimulus(4, 1'b1);
        stepTo(lastS + lastLat + 1);
        fillRandom(2);
        applyStimulus(2, 1'b1);
        stepTo(lastS + lastLat + 2);

        // Oversized request clamps to the buffer depth.
        fillRandom(DEPTH);
        applyStimulus(12, 1'b1);
        stepTo(lastS + lastLat + 5);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
